prog_loader: RTL and testbench

- Byte-stream program loader: the writer side of the CPU's program memory. It turns bytes presented on the dedicated input pins into write cycles on the CPU's common-bus memory port.
- Sits beside tt_um_EightBitCommonBusCPU. Holds the CPU halted while a program image is streamed in, then releases it.
- Frame format: start byte, length byte, N payload bytes, checksum byte.

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/prog_loader_strobe_sync.sv | 34 +++
 rtl/prog_loader.sv | 128 ++++++++++++
 tb/tb_prog_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_pkg
//  Description : Shared types and constants for the byte-stream program loader.
//  Revision    : 1.0  initial release
// ============================================================================
package prog_loader_pkg;

    localparam logic [7:0] c_start_byte = 8'hA5;
    localparam int         c_csum_w     = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_strobe_sync.sv
`default_nettype none
// ============================================================================
//  Module      : strobe_sync
//  Description : Two-flop synchronizer plus registered rising-edge detector.
//  Revision    : 1.0  initial release
// ============================================================================
module strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // o_rise is asserted three clocks after the pin rises, for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            o_rise <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            o_rise <= r_sync & ~r_prev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Parses start/length/payload/checksum frames from pin bytes
//                and writes the payload into CPU program memory.
//  Revision    : 1.0  initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W     = 4,
    parameter logic [7:0] START_BYTE = c_start_byte
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        ld_data,
    input  logic              ld_strobe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_halt,
    output logic              done,
    output logic              err,
    output logic              loaded
);

    localparam logic [8:0] c_cap = 9'd1 << ADDR_W;

    logic                r_ev;
    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_cnt;
    logic [c_csum_w-1:0] r_sum;

    strobe_sync u_strobe_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (ld_strobe),
        .o_rise  (r_ev)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_sum     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_halt  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            loaded    <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_ev && ld_data == START_BYTE) begin
                        r_state  <= ST_LEN;
                        cpu_halt <= 1'b1;
                        r_addr   <= '0;
                        r_sum    <= '0;
                    end
                end
                ST_LEN: begin
                    if (r_ev) begin
                        if ({1'b0, ld_data} > c_cap) begin
                            r_state <= ST_ERR;
                            err     <= 1'b1;
                        end else if (ld_data == 8'd0) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state <= ST_DATA;
                            r_cnt   <= ld_data;
                            r_addr  <= '0;
                            r_sum   <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (r_ev) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= r_addr;
                        mem_wdata <= ld_data;
                        r_sum     <= r_sum + ld_data;
                        r_addr    <= r_addr + 1'b1;
                        r_cnt     <= r_cnt - 8'd1;
                        if (r_cnt == 8'd1) begin
                            r_state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (r_ev) begin
                        if (ld_data == r_sum) begin
                            r_state  <= ST_DONE;
                            done     <= 1'b1;
                            loaded   <= 1'b1;
                            cpu_halt <= 1'b0;
                        end else begin
                            r_state <= ST_ERR;
                            err     <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                ST_ERR: begin
                    // cpu_halt stays high so a corrupt image can never run
                    if (r_ev && ld_data == START_BYTE) begin
                        r_state <= ST_LEN;
                        err     <= 1'b0;
                        r_addr  <= '0;
                        r_sum   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader with a frame-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prog_loader;

    localparam int         c_addr_w = 4;
    localparam logic [7:0] c_start  = 8'hA5;
    localparam int         c_cap    = 1 << c_addr_w;

    typedef logic [7:0] bq_t [$];

    logic                clk;
    logic                rst;
    logic [7:0]          ld_data;
    logic                ld_strobe;
    logic                mem_we;
    logic [c_addr_w-1:0] mem_addr;
    logic [7:0]          mem_wdata;
    logic                cpu_halt;
    logic                done;
    logic                err;
    logic                loaded;

    int tests_run = 0;
    int fails     = 0;

    int exp_w [$];
    int act_w [$];
    int exp_done = 0;
    int act_done = 0;
    logic m_halt   = 1'b0;
    logic m_err    = 1'b0;
    logic m_loaded = 1'b0;

    prog_loader #(.ADDR_W(c_addr_w), .START_BYTE(c_start)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_data   (ld_data),
        .ld_strobe (ld_strobe),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_halt  (cpu_halt),
        .done      (done),
        .err       (err),
        .loaded    (loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) act_w.push_back((int'(mem_addr) << 8) | int'(mem_wdata));
            if (done)   act_done++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        assert (obs === exp_v)
        else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
        end
    endtask

    // Frame-level reference: walks the byte stream, collecting expected writes
    // and the outcome of the last frame seen.
    task automatic model_stream(input bq_t s);
        int i;
        int n;
        logic [7:0] sum;
        i = 0;
        while (i < s.size()) begin
            if (s[i] != c_start) begin
                i++;
                continue;
            end
            i++;
            m_halt = 1'b1;
            m_err  = 1'b0;
            if (i >= s.size()) return;
            n = int'(s[i]);
            i++;
            if (n > c_cap) begin
                m_err = 1'b1;
                continue;
            end
            sum = 8'd0;
            for (int k = 0; k < n; k++) begin
                if (i >= s.size()) return;
                exp_w.push_back((k << 8) | int'(s[i]));
                sum = sum + s[i];
                i++;
            end
            if (i >= s.size()) return;
            if (s[i] == sum) begin
                m_halt   = 1'b0;
                m_loaded = 1'b1;
                exp_done++;
            end else begin
                m_err = 1'b1;
            end
            i++;
        end
    endtask

    // Strobe rises #1 after an edge; lat reports the cycle mem_we is first seen.
    task automatic send_byte(input logic [7:0] b, input int hold, output int lat);
        lat = 0;
        @(posedge clk); #1;
        ld_data   = b;
        ld_strobe = 1'b1;
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk); #1;
            if (mem_we && lat == 0) lat = k;
        end
        ld_strobe = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            ld_data = 8'($urandom);
        end
    endtask

    task automatic send_stream(input bq_t s);
        int lat;
        foreach (s[i]) send_byte(s[i], 6, lat);
    endtask

    task automatic compare_all(input string tag);
        int n;
        repeat (3) @(posedge clk);
        #1;
        check({tag, ".nwrites"}, act_w.size(), exp_w.size());
        n = (act_w.size() < exp_w.size()) ? act_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) check({tag, ".write"}, act_w[i], exp_w[i]);
        check({tag, ".done"},   act_done, exp_done);
        check({tag, ".err"},    err,      m_err);
        check({tag, ".halt"},   cpu_halt, m_halt);
        check({tag, ".loaded"}, loaded,   m_loaded);
        act_w.delete();
        exp_w.delete();
        act_done = 0;
        exp_done = 0;
    endtask

    task automatic run(input bq_t s, input string tag);
        model_stream(s);
        send_stream(s);
        compare_all(tag);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".we"},     mem_we,    0);
        check({tag, ".addr"},   mem_addr,  0);
        check({tag, ".wdata"},  mem_wdata, 0);
        check({tag, ".halt"},   cpu_halt,  0);
        check({tag, ".done"},   done,      0);
        check({tag, ".err"},    err,       0);
        check({tag, ".loaded"}, loaded,    0);
    endtask

    initial begin
        bq_t s;
        int  lat;
        int  n;
        logic [7:0] sum;
        logic [7:0] b;

        rst       = 1'b1;
        ld_strobe = 1'b0;
        ld_data   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        run('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66}, "good");
        run('{8'hA5, 8'h02, 8'h01, 8'h02, 8'h04}, "badsum");
        run('{8'hA5, 8'h01, 8'h7F, 8'h7F}, "recover");
        run('{8'hA5, 8'h11}, "overflow");

        s = '{8'hA5, 8'h10};
        for (int i = 0; i < 16; i++) s.push_back(8'h01);
        s.push_back(8'h10);
        run(s, "boundary");

        run('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00}, "zerolen");

        // Long strobe: one event only; write lands one cycle after ev (4 clk).
        model_stream('{8'hA5, 8'h01, 8'h3C, 8'h3C});
        send_byte(8'hA5, 6, lat);
        send_byte(8'h01, 6, lat);
        send_byte(8'h3C, 10, lat);
        check("hold.latency", lat, 4);
        send_byte(8'h3C, 6, lat);
        compare_all("hold");

        // Reset in the middle of the payload.
        s = '{8'hA5, 8'h04, 8'h21, 8'h43};
        model_stream(s);
        send_stream(s);
        compare_all("prereset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("midreset");
        rst = 1'b0;
        m_halt   = 1'b0;
        m_err    = 1'b0;
        m_loaded = 1'b0;
        run('{8'h65, 8'h87}, "postreset");

        for (int r = 0; r < 20; r++) begin
            s.delete();
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == c_start) b = 8'h5A;
                s.push_back(b);
            end
            s.push_back(c_start);
            if (r % 7 == 6) begin
                s.push_back(8'($urandom_range(c_cap + 1, 255)));
            end else begin
                n   = $urandom_range(0, c_cap);
                sum = 8'd0;
                s.push_back(8'(n));
                for (int k = 0; k < n; k++) begin
                    b = 8'($urandom);
                    s.push_back(b);
                    sum = sum + b;
                end
                if ($urandom_range(0, 3) == 0) sum = sum ^ 8'($urandom_range(1, 255));
                s.push_back(sum);
            end
            run(s, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
